// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern of 1..MAX_LEN bits,
// overlapping/non-overlapping match modes and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    typedef enum logic [0:0] {
        StFill,
        StArmed
    } state_e;

    localparam logic [LEN_W-1:0]   MaxLen     = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] DefPattern = MAX_LEN'(4'b1001);
    localparam logic [LEN_W-1:0]   DefLen     = LEN_W'(4);

    state_e             state;
    logic [MAX_LEN-1:0] history;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] act_pattern;
    logic [LEN_W-1:0]   act_len;
    logic               act_overlap;

    logic [MAX_LEN-1:0] history_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               cfg_valid;
    logic               armed_next;
    logic               hit;
    logic               count_full;

    always_comb begin
        history_next = {history[MAX_LEN-2:0], in};
        fill_next    = (fill == MaxLen) ? fill : fill + LEN_W'(1);
        cfg_valid    = (pat_len != '0) && (pat_len <= MaxLen);
        count_full   = (match_count == {CNT_W{1'b1}});
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (LEN_W'(i) < act_len);
        end
        // Once armed the window stays full until a non-overlap match clears it.
        armed_next = (state == StArmed) || (fill_next >= act_len);
        hit        = armed_next && (((history_next ^ act_pattern) & len_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StFill;
            history     <= '0;
            fill        <= '0;
            act_pattern <= DefPattern;
            act_len     <= DefLen;
            act_overlap <= 1'b1;
            out         <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
        end else begin
            out     <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_load) begin
                if (cfg_valid) begin
                    act_pattern <= pattern;
                    act_len     <= pat_len;
                    act_overlap <= overlap;
                    history     <= '0;
                    fill        <= '0;
                    state       <= StFill;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (en) begin
                history <= history_next;
                if (hit) begin
                    out <= 1'b1;
                    if (!count_full) begin
                        match_count <= match_count + CNT_W'(1);
                    end
                    if (act_overlap) begin
                        fill  <= fill_next;
                        state <= StArmed;
                    end else begin
                        fill  <= '0;
                        state <= StFill;
                    end
                end else begin
                    fill  <= fill_next;
                    state <= armed_next ? StArmed : StFill;
                end
            end
        end
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector and successor to the fixed 1001 detector in the fsm area. It samples one serial bit per enabled clock and compares the most recent bits against a runtime-loadable pattern of 1..MAX_LEN bits. It supports overlapping and non-overlapping match modes, emits a one-cycle match pulse, and keeps a saturating match counter. It sits between a serial input source and downstream control or status logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits; must be >= 4.
CNT_W, 8, width of match_count.
LEN_W, $clog2(MAX_LEN+1), width of pat_len; derived, do not override.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  sample enable; in is consumed only on edges where en=1.
in  input  1  serial data bit.
cfg_load  input  1  latch pattern, pat_len and overlap on this edge.
pattern  input  MAX_LEN  pattern bits; pattern[pat_len-1] is the first bit received, pattern[0] the last.
pat_len  input  LEN_W  pattern length; valid range 1..MAX_LEN.
overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
out  output  1  registered match pulse.
match_count  output  CNT_W  saturating count of matches.
cfg_err  output  1  one-cycle pulse when cfg_load carries an invalid pat_len.

Behaviour:
- Reset values:
  - out=0, cfg_err=0, match_count=0.
  - history=0, fill count=0, state=FILL.
  - Active config: pattern=0...01001, len=4, overlap=1.
- Priority on each edge: reset, then cfg_load, then en.
- cfg_load with pat_len in 1..MAX_LEN:
  - Latches the new config and clears history and fill count.
  - Sets state to FILL and out to 0.
  - match_count is held.
  - Any en/in on that edge is dropped.
- cfg_load with pat_len=0 or pat_len>MAX_LEN:
  - Config, history, state and match_count are unchanged.
  - cfg_err=1 for one cycle.
  - The en/in bit on that edge is also dropped.
- en=0 (no cfg_load): history, state and match_count hold; out=0.
- en=1: history shifts left, inserting in at bit 0. Fill count increments, saturating at MAX_LEN.
- Match condition, evaluated on the updated history:
  - fill count >= len; and
  - history[len-1:0] == pattern[len-1:0].
  - Bits above len-1 are ignored.
- Latency: out goes high on the same edge that samples the final pattern bit, so it is visible for exactly the next cycle. out is never high for two consecutive cycles unless consecutive sampled bits each complete a match (only possible with overlap=1).
- FSM states:
  - FILL: fill count < len. Moves to ARMED when fill count reaches len.
  - ARMED: matches are evaluated.
    - On a match with overlap=1, stay in ARMED.
    - On a match with overlap=0, clear fill count to 0 and go to FILL. The history content is irrelevant after the clear.
- match_count increments on each out pulse and saturates at 2^CNT_W-1 (no wrap).
- A runtime change of the overlap input has no effect until the next valid cfg_load.
- Reset asserted mid-stream discards partial matches; the block returns to the default 1001 config.

Test Plan:
- Reset, default config; en=1; in = 1,0,0,1 -> out=1 only in the cycle after the 4th bit's edge; match_count=1.
- Default config (overlap=1); in = 1,0,0,1,0,0,1 -> out pulses after bits 4 and 7; match_count=2.
- cfg_load pattern=1001, pat_len=4, overlap=0; in = 1,0,0,1,0,0,1 -> single pulse after bit 4; match_count=1. Continuing with 0,0,1 -> second pulse after bit 10.
- cfg_load pattern=8'b10110011, pat_len=8; feed those bits with en low for 3 cycles after bit 5 -> one pulse after bit 8; out=0 throughout the en-low cycles.
- CNT_W=2; pattern=1, pat_len=1; in = 1 for 5 enabled cycles -> out high for 5 consecutive cycles; match_count sequence 1,2,3,3,3.
- Error and mid-stream reset:
  - cfg_load with pat_len=0 -> cfg_err pulse; detection of 1001 continues unchanged.
  - Reset after in = 1,0,0, then in=1 -> no pulse; match_count=0.
